// File: rtl/nn_pkg.sv
// nn_pkg - shared types and constants for the neuron datapath blocks.
//   word_t          : signed Q8.8 data word
//   ONE / ZERO      : Q8.8 constants
//   feeder_state_e  : sequencer states used by sample_feeder
package nn_pkg;

    localparam int WORD_BITS = 16;

    typedef logic signed [WORD_BITS-1:0] word_t;

    localparam word_t ONE  = 16'h0100;
    localparam word_t ZERO = 16'h0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_PULSE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_ADVANCE,
        S_DONE
    } feeder_state_e;

endpackage

// File: rtl/sample_mem.sv
// sample_mem - DEPTH-entry register file holding one training sample per slot
// (N input words plus one target word).
//   clk, rst_n      : clock, synchronous active-low reset (read register only)
//   wr_en/wr_addr   : write port, writes {wr_y, wr_x} into slot wr_addr
//   rd_en/rd_addr   : registered read port; rd_x/rd_y update only on rd_en
// Slot storage itself is never reset; only the read register clears, so the
// presented sample reads as zero after reset.
module sample_mem
    import nn_pkg::*;
#(
    parameter int N     = 6,
    parameter int BITS  = WORD_BITS,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [N-1:0][BITS-1:0] wr_x,
    input  logic [BITS-1:0]        wr_y,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [N-1:0][BITS-1:0] rd_x,
    output logic [BITS-1:0]        rd_y
);

    // Word N of each slot is the target; words 0..N-1 are the inputs.
    logic [N:0][BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= {wr_y, wr_x};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_x <= '0;
            rd_y <= '0;
        end else if (rd_en) begin
            rd_x <= mem[rd_addr][N-1:0];
            rd_y <= mem[rd_addr][N];
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// sample_feeder - handshake-driven dataset sequencer in front of ArchCTRL.
// Presents one stored sample at a time, pulses TR (train) or VL (validate),
// then waits for the watched phase flag (BPO in train, FPO in validate) to
// rise and fall before advancing; loops over n_samples x n_epochs.
//   clk, rst_n        : clock, synchronous active-low reset
//   wr_en/addr/x/y    : sample slot load port (ignored while busy)
//   n_samples/n_epochs/mode/start : run configuration, latched on start
//   FPO, BPO          : phase flags from ArchCTRL
//   y                 : network output (loss feature only)
//   TR, VL            : one-cycle request pulses to ArchCTRL
//   x, y_true         : presented sample, registered
//   sample_idx, epoch_idx, busy, done, err : run status
// Optional: define SAMPLE_FEEDER_LOSS_EN to add loss / loss_valid, an
// epoch-wise saturating sum of |y - y_true|.
module sample_feeder
    import nn_pkg::*;
#(
    parameter int N       = 6,
    parameter int BITS    = WORD_BITS,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [N-1:0][BITS-1:0] wr_x,
    input  logic [BITS-1:0]        wr_y,
    input  logic [AW:0]            n_samples,
    input  logic [7:0]             n_epochs,
    input  logic                   mode,
    input  logic                   start,
    input  logic                   FPO,
    input  logic                   BPO,
    input  logic [BITS-1:0]        y,
    output logic                   TR,
    output logic                   VL,
    output logic [N-1:0][BITS-1:0] x,
    output logic [BITS-1:0]        y_true,
    output logic [AW-1:0]          sample_idx,
    output logic [7:0]             epoch_idx,
    output logic                   busy,
    output logic                   done,
`ifdef SAMPLE_FEEDER_LOSS_EN
    output logic [BITS+7:0]        loss,
    output logic                   loss_valid,
`endif
    output logic                   err
);

    localparam int WW = $clog2(TIMEOUT + 1);

    feeder_state_e state;
    logic [AW:0]   ns_r;      // samples per epoch, clamped to 1..DEPTH
    logic [7:0]    last_ep;   // index of the final epoch
    logic          mode_r;
    logic [WW-1:0] wcnt;

    logic watched, last_smp, tmo, start_acc;

    assign watched   = mode_r ? FPO : BPO;
    assign last_smp  = ({1'b0, sample_idx} == ns_r - 1'b1);
    assign tmo       = (wcnt == WW'(TIMEOUT));
    assign start_acc = (state == S_IDLE) && start;

    // The read register of the slot memory is the x / y_true output register;
    // it is loaded only in PRESENT, so the sample holds for the whole phase.
    sample_mem #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_x    (wr_x),
        .wr_y    (wr_y),
        .rd_en   (state == S_PRESENT),
        .rd_addr (sample_idx),
        .rd_x    (x),
        .rd_y    (y_true)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ns_r       <= '0;
            last_ep    <= '0;
            mode_r     <= 1'b0;
            wcnt       <= '0;
            sample_idx <= '0;
            epoch_idx  <= '0;
            TR         <= 1'b0;
            VL         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            TR   <= 1'b0;
            VL   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_samples == '0)
                            ns_r <= (AW+1)'(1);
                        else if (n_samples > (AW+1)'(DEPTH))
                            ns_r <= (AW+1)'(DEPTH);
                        else
                            ns_r <= n_samples;
                        last_ep    <= (n_epochs == 8'd0) ? 8'd0 : n_epochs - 8'd1;
                        mode_r     <= mode;
                        sample_idx <= '0;
                        epoch_idx  <= '0;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    TR    <= !mode_r;
                    VL    <= mode_r;
                    state <= S_PULSE;
                end
                S_PULSE: begin
                    // A flag already high here is ignored; counting starts in WAIT_HI.
                    wcnt  <= '0;
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if ((state == S_WAIT_HI) && watched) begin
                        wcnt  <= '0;
                        state <= S_WAIT_LO;
                    end else if ((state == S_WAIT_LO) && !watched) begin
                        wcnt  <= '0;
                        state <= S_ADVANCE;
                    end else if (tmo) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        TR    <= 1'b0;
                        VL    <= 1'b0;
                        wcnt  <= '0;
                        state <= S_IDLE;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_ADVANCE: begin
                    if (last_smp) begin
                        sample_idx <= '0;
                        if (epoch_idx == last_ep) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            epoch_idx <= epoch_idx + 8'd1;
                            state     <= S_PRESENT;
                        end
                    end else begin
                        sample_idx <= sample_idx + 1'b1;
                        state      <= S_PRESENT;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SAMPLE_FEEDER_LOSS_EN
    localparam int LW = BITS + 8;

    logic [LW-1:0]        acc;
    logic signed [BITS:0] diff;
    logic [BITS:0]        absd;
    logic [LW:0]          sum;
    logic [LW-1:0]        acc_next;
    logic                 fall_evt;

    // One extra bit keeps the difference of two Q8.8 words exact.
    assign diff     = $signed({y[BITS-1], y}) - $signed({y_true[BITS-1], y_true});
    assign absd     = diff[BITS] ? $unsigned(-diff) : $unsigned(diff);
    assign sum      = {1'b0, acc} + {{(LW-BITS){1'b0}}, absd};
    assign acc_next = sum[LW] ? {LW{1'b1}} : sum[LW-1:0];
    assign fall_evt = (state == S_WAIT_LO) && !watched;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            loss       <= '0;
            loss_valid <= 1'b0;
        end else begin
            loss_valid <= 1'b0;
            if (start_acc) begin
                acc <= '0;
            end else if (fall_evt) begin
                if (last_smp) begin
                    // Epoch complete: publish the sum and start the next one fresh.
                    loss       <= acc_next;
                    loss_valid <= 1'b1;
                    acc        <= '0;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end
`else
    logic unused_loss_in;
    assign unused_loss_in = ^{y, start_acc};
`endif

endmodule

// File: tb/tb_sample_feeder.sv
// Bench for sample_feeder: a slot-memory model produces the expected pulse
// sequence for each run; one negedge process compares every TR/VL pulse and
// done pulse against it, while a small responder plays ArchCTRL.
module tb_sample_feeder;
  localparam int N = 6, BITS = 16, DEPTH = 8, TIMEOUT = 15, AW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic wr_en = 0, mode = 0, start = 0, fpo, bpo;
  logic [AW-1:0] wr_addr = '0;
  logic [N-1:0][BITS-1:0] wr_x = '0;
  logic [BITS-1:0] wr_y = '0, y = '0;
  logic [AW:0] n_samples = '0;
  logic [7:0] n_epochs = '0;
  logic tr, vl, busy, done, err;
  logic [N-1:0][BITS-1:0] x;
  logic [BITS-1:0] y_true;
  logic [AW-1:0] sample_idx;
  logic [7:0] epoch_idx;
`ifdef SAMPLE_FEEDER_LOSS_EN
  logic [BITS+7:0] loss;
  logic loss_valid;
`endif

  sample_feeder #(.N(N), .BITS(BITS), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y),
    .n_samples(n_samples), .n_epochs(n_epochs), .mode(mode), .start(start),
    .FPO(fpo), .BPO(bpo), .y(y), .TR(tr), .VL(vl), .x(x), .y_true(y_true),
    .sample_idx(sample_idx), .epoch_idx(epoch_idx), .busy(busy), .done(done),
`ifdef SAMPLE_FEEDER_LOSS_EN
    .loss(loss), .loss_valid(loss_valid),
`endif
    .err(err));

  typedef struct {
    int idx; int ep; logic [N-1:0][BITS-1:0] xv; logic [BITS-1:0] yv; logic md;
  } exp_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int start_cyc = -1, last_pulse_cyc = -1, last_fall = 0;
  int pulse_cnt = 0, done_cnt = 0, lv_cnt = 0;
  logic [127:0] last_loss = '0;
  exp_t expq[$];
  exp_t ce;
  int idx_log[$], ep_log[$];
  logic [BITS-1:0] x0_log[$], yt_log[$];
  logic [N-1:0][BITS-1:0] mx [DEPTH];
  logic [BITS-1:0] my [DEPTH];
  bit resp_en = 1, chk_stable = 1;
  int resp_hold = 3;
  logic prev_pulse = 0;
  int exp_idx[6] = '{0, 1, 2, 0, 1, 2};
  int exp_ep[6]  = '{0, 0, 0, 1, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Compare process: every pulse must be the next sample the model predicts.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tr || vl) begin
        pulse_cnt++;
        chk("tr_vl_exclusive", 128'(tr & vl), 128'(0));
        chk("pulse_width", 128'(prev_pulse), 128'(0));
        chk("busy_in_run", 128'(busy), 128'(1));
        if (expq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_pulse: got idx %0d expected none", sample_idx);
        end else begin
          ce = expq.pop_front();
          chk("pulse_kind", 128'(vl), 128'(ce.md));
          chk("sample_idx", 128'(sample_idx), 128'(ce.idx));
          chk("epoch_idx", 128'(epoch_idx), 128'(ce.ep));
          chk("x", 128'(x), 128'(ce.xv));
          chk("y_true", 128'(y_true), 128'(ce.yv));
          if (start_cyc > last_pulse_cyc) chk("start_to_pulse", 128'(cyc - start_cyc), 128'(2));
          else chk("fall_to_pulse", 128'(cyc - last_fall), 128'(3));
        end
        idx_log.push_back(int'(sample_idx)); ep_log.push_back(int'(epoch_idx));
        x0_log.push_back(x[0]); yt_log.push_back(y_true);
        last_pulse_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_all_samples", 128'(expq.size()), 128'(0));
        chk("fall_to_done", 128'(cyc - last_fall), 128'(2));
      end
`ifdef SAMPLE_FEEDER_LOSS_EN
      if (loss_valid) begin lv_cnt++; last_loss = 128'(loss); end
`endif
    end
    prev_pulse = tr | vl;
  end

  // ArchCTRL stand-in: raise the watched flag two cycles after a request,
  // hold it resp_hold cycles, then drop it.
  initial begin : responder
    logic r_md;
    logic [N-1:0][BITS-1:0] r_x;
    bpo = 0; fpo = 0;
    forever begin
      @(negedge clk);
      if (resp_en && rst_n && (tr || vl)) begin
        r_md = vl;
        repeat (2) @(negedge clk);
        if (r_md) fpo = 1; else bpo = 1;
        r_x = x;
        for (int i = 0; i < resp_hold; i++) begin
          @(negedge clk);
          if (chk_stable) chk("x_stable", 128'(x), 128'(r_x));
        end
        bpo = 0; fpo = 0; last_fall = cyc;
      end
    end
  end

  task automatic write_slot(int a, logic [N-1:0][BITS-1:0] xv, logic [BITS-1:0] yv);
    @(negedge clk);
    wr_en = 1; wr_addr = AW'(a); wr_x = xv; wr_y = yv; mx[a] = xv; my[a] = yv;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic launch(int ns, int ne, bit md, bit wr, int wa,
                        logic [N-1:0][BITS-1:0] xv, logic [BITS-1:0] yv);
    int eff;
    exp_t e;
    eff = (ne == 0) ? 1 : ne;
    @(negedge clk);
    if (wr) begin
      wr_en = 1; wr_addr = AW'(wa); wr_x = xv; wr_y = yv; mx[wa] = xv; my[wa] = yv;
    end
    for (int ep = 0; ep < eff; ep++)
      for (int s = 0; s < ns; s++) begin
        e.idx = s; e.ep = ep; e.xv = mx[s]; e.yv = my[s]; e.md = md;
        expq.push_back(e);
      end
    n_samples = (AW+1)'(ns); n_epochs = 8'(ne); mode = md; start = 1; start_cyc = cyc;
    @(negedge clk);
    start = 0; wr_en = 0;
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("err_cleared_by_start", 128'(err), 128'(0));
  endtask

  task automatic wait_end();
    bit fin;
    fin = 0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      if (done || err) fin = 1;
    end
    chk("run_finished_with_done", 128'(fin & done), 128'(1));
    @(negedge clk);
    chk("busy_after_done", 128'(busy), 128'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [N-1:0][BITS-1:0] xv;
    int p0, d0, e0, ec;
    bit seen;

    repeat (3) @(negedge clk);
    chk("rst_tr_vl", 128'({tr, vl}), 128'(0));
    chk("rst_x", 128'(x), 128'(0));
    chk("rst_y_true", 128'(y_true), 128'(0));
    chk("rst_idx", 128'({sample_idx, epoch_idx}), 128'(0));
    chk("rst_busy_done_err", 128'({busy, done, err}), 128'(0));
    rst_n = 1;

    for (int a = 0; a < DEPTH; a++) begin
      for (int l = 0; l < N; l++) xv[l] = 16'(a * 256 + l * 16 + 1);
      if (a < 2) xv[0] = 16'hFEEF;
      write_slot(a, xv, (a < 2) ? 16'h0100 : 16'(a * 16 + 3));
    end

    // Two training samples, one epoch.
    p0 = pulse_cnt; d0 = done_cnt;
    idx_log.delete(); x0_log.delete(); yt_log.delete();
    launch(2, 1, 0, 0, 0, '0, '0);
    wait_end();
    chk("train_pulse_count", 128'(pulse_cnt - p0), 128'(2));
    chk("train_done_count", 128'(done_cnt - d0), 128'(1));
    if (x0_log.size() > 0) begin
      chk("lit_first_x0", 128'(x0_log[0]), 128'(16'hFEEF));
      chk("lit_first_y_true", 128'(yt_log[0]), 128'(16'h0100));
    end

    // Validate, 3 samples x 2 epochs, with a stray start mid-run.
    p0 = pulse_cnt; idx_log.delete(); ep_log.delete();
    launch(3, 2, 1, 0, 0, '0, '0);
    repeat (5) @(negedge clk);
    n_samples = 1; mode = 0; start = 1;
    @(negedge clk);
    start = 0;
    wait_end();
    chk("vl_pulse_count", 128'(pulse_cnt - p0), 128'(6));
    chk("vl_log_len", 128'(idx_log.size()), 128'(6));
    for (int i = 0; i < 6 && i < idx_log.size(); i++) begin
      chk("lit_idx_seq", 128'(idx_log[i]), 128'(exp_idx[i]));
      chk("lit_ep_seq", 128'(ep_log[i]), 128'(exp_ep[i]));
    end

    // Full depth, n_epochs = 0 behaves as one epoch.
    p0 = pulse_cnt;
    launch(DEPTH, 0, 0, 0, 0, '0, '0);
    wait_end();
    chk("full_depth_pulses", 128'(pulse_cnt - p0), 128'(DEPTH));

    // No controller: timeout.
    resp_en = 0; d0 = done_cnt;
    launch(1, 1, 0, 0, 0, '0, '0);
    seen = 0; ec = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (err) begin seen = 1; ec = cyc; end
    end
    chk("timeout_err_set", 128'(seen), 128'(1));
    chk("timeout_latency", 128'(ec - last_pulse_cyc), 128'(TIMEOUT + 2));
    chk("timeout_busy", 128'(busy), 128'(0));
    repeat (3) @(negedge clk);
    chk("timeout_no_done", 128'(done_cnt - d0), 128'(0));
    chk("timeout_err_sticky", 128'(err), 128'(1));
    resp_en = 1;
    launch(2, 1, 0, 0, 0, '0, '0);
    wait_end();

    // Reset while in WAIT_LO.
    resp_hold = 8; d0 = done_cnt;
    launch(2, 1, 0, 0, 0, '0, '0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bpo) seen = 1;
    end
    chk("reset_test_bpo_seen", 128'(seen), 128'(1));
    repeat (2) @(negedge clk);
    chk_stable = 0; rst_n = 0;
    @(negedge clk);
    chk("midrst_tr_vl", 128'({tr, vl}), 128'(0));
    chk("midrst_busy_err", 128'({busy, err, done}), 128'(0));
    chk("midrst_x", 128'(x), 128'(0));
    rst_n = 1;
    for (int i = 0; i < 20 && bpo; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - d0), 128'(0));
    expq.delete(); chk_stable = 1; resp_hold = 3;
    launch(2, 1, 0, 0, 0, '0, '0);
    wait_end();

    // start and wr_en to slot 0 in the same cycle.
    x0_log.delete();
    xv = mx[0]; xv[0] = 16'hA5A5;
    launch(1, 1, 0, 1, 0, xv, 16'h1234);
    wait_end();
    if (x0_log.size() > 0) chk("lit_same_cycle_write", 128'(x0_log[0]), 128'(16'hA5A5));
    else chk("same_cycle_pulse_seen", 128'(0), 128'(1));

`ifdef SAMPLE_FEEDER_LOSS_EN
    for (int a = 0; a < 4; a++) write_slot(a, mx[a], 16'h0100);
    y = 16'h0080; e0 = lv_cnt;
    launch(4, 1, 0, 0, 0, '0, '0);
    wait_end();
    chk("loss_valid_count", 128'(lv_cnt - e0), 128'(1));
    chk("lit_loss_sum", last_loss, 128'(24'h000200));
`else
    e0 = 0;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_feeder.md
# sample_feeder

Dataset-side initiator for the phase controller. Holds up to DEPTH training samples (input vector plus target) in local storage, presents one sample at a time on the neuron input bus, and pulses TR (train) or VL (validate) into `ArchCTRL`. It then waits for the controller's phase outputs to complete before advancing, iterating over a programmed number of epochs. It replaces hand-timed stimulus with a handshake-driven sequencer that sits between host loading logic and the `ArchCTRL` + neuron datapath.

## Interface
- N, 6, inputs per sample (matches the neuron fan-in).
- BITS, 16, word width; signed Q8.8.
- DEPTH, 8, sample slots; power of two, ≥2.
- TIMEOUT, 1023, maximum cycles to wait for any phase edge.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write one sample slot; ignored while busy.
- wr_addr  in  $clog2(DEPTH)  slot index.
- wr_x  in  N×BITS  sample inputs.
- wr_y  in  BITS  sample target.
- n_samples  in  $clog2(DEPTH)+1  samples per epoch, 1..DEPTH; sampled at start.
- n_epochs  in  8  epoch count; sampled at start; 0 treated as 1.
- mode  in  1  0 = train (TR), 1 = validate (VL); sampled at start.
- start  in  1  single-cycle request; honoured only in IDLE.
- FPO  in  1  forward output-phase flag from `ArchCTRL`.
- BPO  in  1  backward output-phase flag from `ArchCTRL`.
- y  in  BITS  network output; used only with the loss feature.
- TR  out  1  train request pulse to `ArchCTRL`.
- VL  out  1  validate request pulse to `ArchCTRL`.
- x  out  N×BITS  current sample inputs, registered.
- y_true  out  BITS  current sample target, registered.
- sample_idx  out  $clog2(DEPTH)  index of the presented sample.
- epoch_idx  out  8  current epoch, counting from 0.
- busy  out  1  high from the start acceptance cycle until DONE.
- done  out  1  one-cycle pulse on normal completion.
- err  out  1  sticky timeout flag; cleared by the next accepted start or by reset.

## Operation
- States: IDLE → PRESENT → PULSE → WAIT_HI → WAIT_LO → ADVANCE → (PRESENT | DONE) → IDLE.
- IDLE
  - wr_en writes the slot.
  - start latches n_samples, n_epochs and mode, clears the indices and err, then moves to PRESENT.
- PRESENT: loads x and y_true from slot sample_idx.
- PULSE: asserts TR (mode 0) or VL (mode 1) for exactly one cycle.
- Watched signal: BPO in train mode, FPO in validate mode.
- WAIT_HI: waits for the watched signal to go high.
- WAIT_LO: waits for the watched signal to go low. This is the sample-complete point.
- ADVANCE
  - sample_idx increments.
  - When it reaches n_samples−1 the sample index wraps to 0 and epoch_idx increments.
  - After the last epoch, go to DONE; otherwise go to PRESENT.
- DONE: pulses done for one cycle, drops busy, returns to IDLE.
- Timeout
  - A wait counter runs in WAIT_HI and WAIT_LO and reloads on every state change.
  - If it reaches TIMEOUT: set err, drop busy, force TR and VL low, go to IDLE.
  - No done pulse on timeout.
- x and y_true hold stable from PRESENT until the next PRESENT, so the controller sees a constant sample for the whole phase sequence.
- Simultaneous events
  - start together with wr_en in IDLE: the write completes and the run starts; slot data is read in PRESENT, one cycle later.
  - start while busy is ignored.

## Timing
- Reset values
  - All outputs are 0; the FSM is in IDLE.
  - Slot storage is not reset (contents are undefined until written).
- Reset mid-run aborts immediately: no done pulse, err cleared.
- start → busy: busy high the cycle after start is accepted.
- start → TR/VL: 2 cycles (IDLE→PRESENT→PULSE).
- Watched signal falling → next TR/VL: 3 cycles (WAIT_LO→ADVANCE→PRESENT→PULSE).
- Last watched fall → done: 2 cycles.
- The watched signal already high in PULSE is not counted; WAIT_HI is entered only after PULSE.

## Configuration
- SAMPLE_FEEDER_LOSS_EN defined:
  - Adds output `loss` [BITS+8-1:0] and output `loss_valid` [1].
  - In WAIT_LO, on the watched falling edge, |y − y_true| is added to the accumulator. The accumulator is unsigned and saturates at all-ones.
  - The accumulator clears at each epoch start.
  - loss_valid pulses with the final sample of each epoch, and `loss` holds that sum until the next epoch ends.
- SAMPLE_FEEDER_LOSS_EN undefined: no loss ports, no accumulator, and y is unused.

## Structure
- Shared package `nn_pkg`:
  - `word_t` (BITS-wide signed Q8.8).
  - Q8.8 constants (ONE = 16'h0100).
  - The FSM state enum `feeder_state_e`.
- Sub-module `sample_mem`: DEPTH×(N+1)×BITS register file with one write port and one registered read port.
- The FSM, counters and loss logic live in `sample_feeder`.

## Test plan
- Reset mid-WAIT_LO → next cycle TR=VL=0, busy=0, x=0, err=0; slot data still readable on the next run.
- Write 2 slots (x[0]=16'hFE_EF, y=16'h0100), n_samples=2, n_epochs=1, mode=0, with `ArchCTRL` attached → TR pulses exactly twice (1 cycle each), done once, x stable across each BPO window.
- n_samples=3, n_epochs=2, mode=1 → 6 VL pulses; sample_idx sequence 0,1,2,0,1,2; epoch_idx steps at the 4th pulse.
- BPO held low (no controller), TIMEOUT=15 → err sets 16 cycles after WAIT_HI entry, no done; a following start clears err.
- Loss enabled, y=16'h0080, y_true=16'h0100, 4 samples → loss=16'h0200 with loss_valid after the 4th sample.
- start and wr_en to slot 0 in the same IDLE cycle → the first presented x equals the newly written data.
